// File: rtl/decompress_fifo.sv
// Elastic packet buffer between the decompressor and the global buffer.
// Registered outputs; req is the decompressor's flow-control handshake.
module decompress_fifo #(
  parameter int unsigned PKT_W    = 64,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AFULL_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_valid,
  input  logic [PKT_W-1:0]         wr_data,
  output logic                     global_buffer_req,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [PKT_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             pop_c;
  logic             push_c;
  logic [CNT_W-1:0] fill_next_c;
  logic [CNT_W-1:0] free_next_c;

  // Push/pop qualification and next occupancy; flush suppresses both.
  always_comb begin
    pop_c       = 1'b0;
    push_c      = 1'b0;
    fill_next_c = fill_count;
    free_next_c = '0;
    pop_c       = rd_req && !empty && !flush;
    push_c      = wr_valid && (!full || pop_c) && !flush;
    fill_next_c = fill_count + CNT_W'(push_c) - CNT_W'(pop_c);
    free_next_c = CNT_W'(DEPTH) - fill_next_c;
  end

  // Packet storage; contents are not reset, validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, read port, flow control and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fill_count        <= '0;
      empty             <= 1'b1;
      full              <= 1'b0;
      rd_valid          <= 1'b0;
      rd_data           <= '0;
      global_buffer_req <= 1'b0;
      overflow_err      <= 1'b0;
      underflow_err     <= 1'b0;
    end else if (flush) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fill_count        <= '0;
      empty             <= 1'b1;
      full              <= 1'b0;
      rd_valid          <= 1'b0;
      global_buffer_req <= 1'b1;
      overflow_err      <= 1'b0;
      underflow_err     <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid          <= pop_c;
      fill_count        <= fill_next_c;
      empty             <= (fill_next_c == '0);
      full              <= (fill_next_c == CNT_W'(DEPTH));
      global_buffer_req <= (free_next_c > CNT_W'(AFULL_TH));
      if (wr_valid && full && !pop_c) begin
        overflow_err <= 1'b1;
      end
      if (rd_req && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decompress_fifo.sv
// Bench for decompress_fifo: directed scenarios plus random traffic against a queue model.
module tb_decompress_fifo;

  localparam int unsigned PKT_W    = 64;
  localparam int          DEPTH    = 16;
  localparam int          AFULL_TH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             wr_valid = 1'b0;
  logic [PKT_W-1:0] wr_data = '0;
  logic             global_buffer_req;
  logic             rd_req = 1'b0;
  logic             rd_valid;
  logic [PKT_W-1:0] rd_data;
  logic [4:0]       fill_count;
  logic             empty;
  logic             full;
  logic             overflow_err;
  logic             underflow_err;

  decompress_fifo #(.PKT_W(PKT_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .global_buffer_req(global_buffer_req),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .fill_count(fill_count), .empty(empty), .full(full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered queue of stored packets plus expected flags.
  logic [PKT_W-1:0] q[$];
  bit               m_rv  = 1'b0;
  logic [PKT_W-1:0] m_rd  = '0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  bit               m_req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rv"},    64'(rd_valid), 64'(m_rv));
    chk({tag, "_rd"},    rd_data, m_rd);
    chk({tag, "_fill"},  64'(fill_count), 64'(q.size()));
    chk({tag, "_empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, "_full"},  64'(full), 64'(q.size() == DEPTH));
    chk({tag, "_ovf"},   64'(overflow_err), 64'(m_ovf));
    chk({tag, "_unf"},   64'(underflow_err), 64'(m_unf));
    chk({tag, "_req"},   64'(global_buffer_req), 64'(m_req));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input bit w, input logic [PKT_W-1:0] d,
                      input bit r, input bit f);
    bit do_pop;
    bit do_push;
    wr_valid = w; wr_data = d; rd_req = r; flush = f;
    if (f) begin
      q.delete();
      m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      do_pop  = r && (q.size() != 0);
      do_push = w && ((q.size() < DEPTH) || do_pop);
      if (r && q.size() == 0) m_unf = 1'b1;
      if (w && !do_push) m_ovf = 1'b1;
      m_rv = do_pop;
      if (do_pop) m_rd = q.pop_front();
      if (do_push) q.push_back(d);
    end
    m_req = (DEPTH - q.size()) > AFULL_TH;
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    m_rv = 1'b0; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0; m_req = 1'b0;
    chk_all(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, "_req_low_after_release"}, 64'(global_buffer_req), 64'd0);
  endtask

  initial begin
    // 1: reset then idle
    @(posedge clk); @(posedge clk); #1;
    chk_all("t1_in_reset");
    rst = 1'b0;
    chk("t1_req_low_at_release", 64'(global_buffer_req), 64'd0);
    step("t1_idle", 0, '0, 0, 0);
    chk("t1_req_high", 64'(global_buffer_req), 64'd1);

    // 2: three packets in, three pops out in order
    step("t2_w1", 1, 64'hA1, 0, 0);
    step("t2_w2", 1, 64'hA2, 0, 0);
    step("t2_w3", 1, 64'hA3, 0, 0);
    step("t2_r1", 0, '0, 1, 0);
    chk("t2_d1", rd_data, 64'hA1);
    step("t2_r2", 0, '0, 1, 0);
    chk("t2_d2", rd_data, 64'hA2);
    step("t2_r3", 0, '0, 1, 0);
    chk("t2_d3", rd_data, 64'hA3);
    chk("t2_empty", 64'(empty), 64'd1);
    step("t2_idle", 0, '0, 0, 0);

    // 3: req drops at free == AFULL_TH, returns after one pop
    for (int i = 0; i < 12; i++) step("t3_w", 1, 64'(32'h300 + i), 0, 0);
    chk("t3_req_low", 64'(global_buffer_req), 64'd0);
    step("t3_pop", 0, '0, 1, 0);
    chk("t3_req_rise", 64'(global_buffer_req), 64'd1);

    // 4: fill to DEPTH, overflow drop, then push+pop while full
    for (int i = 0; i < 5; i++) step("t4_w", 1, 64'(32'h400 + i), 0, 0);
    chk("t4_full", 64'(full), 64'd1);
    step("t4_ovf", 1, 64'hFF, 0, 0);
    chk("t4_ovf_flag", 64'(overflow_err), 64'd1);
    chk("t4_fill16", 64'(fill_count), 64'd16);
    step("t4_pushpop", 1, 64'h4FF, 1, 0);
    chk("t4_pushpop_fill", 64'(fill_count), 64'd16);
    chk("t4_pushpop_rv", 64'(rd_valid), 64'd1);
    for (int i = 0; i < DEPTH; i++) step("t4_drain", 0, '0, 1, 0);

    // 5: read while empty with a coincident write
    step("t5_unf", 1, 64'h55, 1, 0);
    chk("t5_unf_flag", 64'(underflow_err), 64'd1);
    chk("t5_no_rv", 64'(rd_valid), 64'd0);
    step("t5_rd", 0, '0, 1, 0);
    chk("t5_d55", rd_data, 64'h55);

    // 6: streaming push/pop pairs across the pointer wrap, then flush
    step("t6_pre1", 1, 64'h600, 0, 0);
    step("t6_pre2", 1, 64'h601, 0, 0);
    for (int i = 0; i < 20; i++) step("t6_pair", 1, 64'(32'h602 + i), 1, 0);
    step("t6_flush", 1, 64'h6EE, 1, 1);
    chk("t6_fill0", 64'(fill_count), 64'd0);
    chk("t6_req", 64'(global_buffer_req), 64'd1);
    chk("t6_errs", 64'({overflow_err, underflow_err}), 64'd0);
    step("t6_after", 0, '0, 1, 0);

    // Mid-stream reset discards everything
    for (int i = 0; i < 5; i++) step("rs_w", 1, 64'(32'h700 + i), 0, 0);
    do_reset("rs");
    step("rs_idle", 0, '0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset("rnd_rst");
        step("rnd_rst_idle", 0, '0, 0, 0);
      end
      step("rnd",
           ($urandom_range(99) < 60),
           {$urandom, $urandom},
           ($urandom_range(99) < 50),
           ($urandom_range(199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
